// File: rtl/regfile_sb.sv
// regfile_sb: register file with write-through bypass and a per-register
// scoreboard (busy bits) guarding write-after-write on destination issue.
// Ports:
//   Clk, Reset (async, active low)
//   LD_REG/DR/D_in        : register write (also clears the busy bit)
//   SR1_in/SR2_in         : read addresses -> SR1_out/SR2_out, SR1_busy/SR2_busy
//   Issue/Issue_DR        : reserve a destination; Issue_stall when refused
//   Flush                 : drop every reservation
//   NZP                   : condition codes of the last written value (registered)
//   Pending               : number of reserved registers (registered)
module regfile_sb #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] D_in,
  input  logic [AW-1:0]    SR1_in,
  input  logic [AW-1:0]    SR2_in,
  output logic [WIDTH-1:0] SR1_out,
  output logic [WIDTH-1:0] SR2_out,
  output logic             SR1_busy,
  output logic             SR2_busy,
  input  logic             Issue,
  input  logic [AW-1:0]    Issue_DR,
  output logic             Issue_stall,
  input  logic             Flush,
  output logic [2:0]       NZP,
  output logic [CW-1:0]    Pending
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [CW-1:0]    pending_q, pending_d;

  logic sr1_hit, sr2_hit, idr_hit;
  logic stall_c, issue_ok;

  // A write in flight this cycle is visible to readers and resolves busy
  assign sr1_hit = LD_REG && (DR == SR1_in);
  assign sr2_hit = LD_REG && (DR == SR2_in);
  assign idr_hit = LD_REG && (DR == Issue_DR);

  assign SR1_out  = sr1_hit ? D_in : regs_q[SR1_in];
  assign SR2_out  = sr2_hit ? D_in : regs_q[SR2_in];
  assign SR1_busy = busy_q[SR1_in] && !sr1_hit;
  assign SR2_busy = busy_q[SR2_in] && !sr2_hit;

  // WAW guard: refuse a second reservation unless the first retires now
  assign stall_c     = Issue && busy_q[Issue_DR] && !idr_hit && !Flush;
  assign issue_ok    = Issue && !stall_c && !Flush;
  assign Issue_stall = stall_c;

  assign NZP     = nzp_q;
  assign Pending = pending_q;

  // Next busy vector: flush dominates; otherwise a same-cycle set beats the clear
  always_comb begin
    busy_d = busy_q;
    if (Flush) begin
      busy_d = '0;
    end else begin
      if (LD_REG)   busy_d[DR]       = 1'b0;
      if (issue_ok) busy_d[Issue_DR] = 1'b1;
    end
  end

  // Pending tracks the popcount of the busy vector after this edge
  always_comb begin
    pending_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pending_d = pending_d + CW'(busy_d[i]);
    end
  end

  // Condition codes of the value being written
  always_comb begin
    nzp_d = nzp_q;
    if (LD_REG) begin
      if (D_in[WIDTH-1])   nzp_d = 3'b100;
      else if (D_in == '0) nzp_d = 3'b010;
      else                 nzp_d = 3'b001;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy_q    <= '0;
      nzp_q     <= 3'b010;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      nzp_q     <= nzp_d;
      pending_q <= pending_d;
    end
  end

  // Register storage
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (LD_REG) begin
      regs_q[DR] <= D_in;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // 16 x 8 instance
  logic        ld, iss, fl;
  logic [2:0]  dr, sr1, sr2, idr;
  logic [15:0] din;
  logic [15:0] sr1_out, sr2_out;
  logic        sr1_busy, sr2_busy, stall;
  logic [2:0]  nzp;
  logic [3:0]  pend;

  // 32 x 16 instance
  logic        w_ld, w_iss, w_fl;
  logic [3:0]  w_dr, w_sr1, w_sr2, w_idr;
  logic [31:0] w_din;
  logic [31:0] w_sr1_out, w_sr2_out;
  logic        w_sr1_busy, w_sr2_busy, w_stall;
  logic [2:0]  w_nzp;
  logic [4:0]  w_pend;

  regfile_sb u_dut (
    .Clk(Clk), .Reset(Reset), .LD_REG(ld), .DR(dr), .D_in(din),
    .SR1_in(sr1), .SR2_in(sr2), .SR1_out(sr1_out), .SR2_out(sr2_out),
    .SR1_busy(sr1_busy), .SR2_busy(sr2_busy), .Issue(iss), .Issue_DR(idr),
    .Issue_stall(stall), .Flush(fl), .NZP(nzp), .Pending(pend)
  );

  regfile_sb #(.WIDTH(32), .DEPTH(16)) u_wide (
    .Clk(Clk), .Reset(Reset), .LD_REG(w_ld), .DR(w_dr), .D_in(w_din),
    .SR1_in(w_sr1), .SR2_in(w_sr2), .SR1_out(w_sr1_out), .SR2_out(w_sr2_out),
    .SR1_busy(w_sr1_busy), .SR2_busy(w_sr2_busy), .Issue(w_iss), .Issue_DR(w_idr),
    .Issue_stall(w_stall), .Flush(w_fl), .NZP(w_nzp), .Pending(w_pend)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic a_ld, input logic [2:0] a_dr, input logic [15:0] a_din,
                       input logic [2:0] a_sr1, input logic [2:0] a_sr2,
                       input logic a_iss, input logic [2:0] a_idr, input logic a_fl);
    ld = a_ld; dr = a_dr; din = a_din; sr1 = a_sr1; sr2 = a_sr2;
    iss = a_iss; idr = a_idr; fl = a_fl;
  endtask

  typedef struct {
    logic        ld;
    logic [2:0]  dr;
    logic [15:0] din;
    logic [2:0]  sr1, sr2;
    logic        iss;
    logic [2:0]  idr;
    logic        fl;
    logic [15:0] e_sr1, e_sr2;
    logic        e_b1, e_b2, e_stall;
    logic [3:0]  e_pend;
    logic [2:0]  e_nzp;
  } vec_t;

  vec_t tbl [8];

  // Reference model: plain arrays updated from the behavioural rules
  logic [15:0] m_regs [8];
  logic        m_busy [8];
  logic [2:0]  m_nzp;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  initial begin
    logic [15:0] e1, e2;
    logic        eb1, eb2, est;
    int          expect_pend;

    //            ld    dr    din        sr1   sr2   iss   idr   fl    e_sr1      e_sr2      b1    b2    stall pend  nzp
    tbl[0] = '{1'b1, 3'd3, 16'h8001, 3'd0, 3'd3, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h8001, 1'b0, 1'b0, 1'b0, 4'd0, 3'b100};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd0, 1'b0, 3'd0, 1'b0, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 3'b100};
    tbl[2] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 3'd5, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 3'b100};
    tbl[3] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd0, 1'b1, 3'd5, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd1, 3'b100};
    tbl[4] = '{1'b1, 3'd5, 16'h0000, 3'd5, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 3'b010};
    tbl[5] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd0, 1'b1, 3'd2, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd1, 3'b010};
    tbl[6] = '{1'b1, 3'd2, 16'h1234, 3'd2, 3'd3, 1'b1, 3'd2, 1'b0, 16'h1234, 16'h8001, 1'b0, 1'b0, 1'b0, 4'd1, 3'b001};
    tbl[7] = '{1'b0, 3'd0, 16'h0000, 3'd2, 3'd3, 1'b0, 3'd0, 1'b0, 16'h1234, 16'h8001, 1'b1, 1'b0, 1'b0, 4'd1, 3'b001};

    Reset = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    w_ld = 1'b0; w_dr = '0; w_din = '0; w_sr1 = '0; w_sr2 = '0; w_iss = 1'b0; w_idr = '0; w_fl = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_pend", 64'(pend), 64'(0));
    chk("rst_nzp", 64'(nzp), 64'(3'b010));
    chk("rst_sr1", 64'(sr1_out), 64'(0));
    chk("rst_wnzp", 64'(w_nzp), 64'(3'b010));
    Reset = 1'b1;

    // Directed table: bypass, read-after-write, WAW stall, set-wins
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      drive(tbl[i].ld, tbl[i].dr, tbl[i].din, tbl[i].sr1, tbl[i].sr2, tbl[i].iss, tbl[i].idr, tbl[i].fl);
      #1;
      chk($sformatf("tbl%0d_sr1", i), 64'(sr1_out), 64'(tbl[i].e_sr1));
      chk($sformatf("tbl%0d_sr2", i), 64'(sr2_out), 64'(tbl[i].e_sr2));
      chk($sformatf("tbl%0d_b1", i), 64'(sr1_busy), 64'(tbl[i].e_b1));
      chk($sformatf("tbl%0d_b2", i), 64'(sr2_busy), 64'(tbl[i].e_b2));
      chk($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].e_stall));
      @(posedge Clk); #1;
      chk($sformatf("tbl%0d_pend", i), 64'(pend), 64'(tbl[i].e_pend));
      chk($sformatf("tbl%0d_nzp", i), 64'(nzp), 64'(tbl[i].e_nzp));
    end

    // Fill the scoreboard (register 2 already reserved)
    expect_pend = 1;
    for (int r = 0; r < 8; r++) begin
      if (r == 2) continue;
      @(negedge Clk);
      drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 3'(r), 1'b0);
      @(posedge Clk); #1;
      expect_pend++;
      chk($sformatf("fill%0d_pend", r), 64'(pend), 64'(expect_pend));
    end
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 3'd2, 1'b0);
    #1 chk("full_stall", 64'(stall), 64'(1));
    @(posedge Clk); #1 chk("full_pend", 64'(pend), 64'(8));

    // Flush overrides a simultaneous issue
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd0, 1'b1, 3'd1, 1'b1);
    #1 chk("flush_stall", 64'(stall), 64'(0));
    chk("flush_b1_pre", 64'(sr1_busy), 64'(1));
    @(posedge Clk); #1 chk("flush_pend", 64'(pend), 64'(0));
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0);
    #1 chk("flush_b1_post", 64'(sr1_busy), 64'(0));

    // Asynchronous reset mid-cycle
    @(negedge Clk);
    drive(1'b1, 3'd6, 16'h7fff, 3'd0, 3'd0, 1'b1, 3'd4, 1'b0);
    @(posedge Clk); #1 chk("pre_rst_nzp", 64'(nzp), 64'(3'b001));
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd4, 1'b1, 3'd4, 1'b0);
    #1 chk("pre_rst_sr1", 64'(sr1_out), 64'(16'h7fff));
    chk("pre_rst_b2", 64'(sr2_busy), 64'(1));
    chk("pre_rst_stall", 64'(stall), 64'(1));
    #1 Reset = 1'b0;
    #1;
    chk("mid_rst_sr1", 64'(sr1_out), 64'(0));
    chk("mid_rst_b2", 64'(sr2_busy), 64'(0));
    chk("mid_rst_stall", 64'(stall), 64'(0));
    chk("mid_rst_pend", 64'(pend), 64'(0));
    chk("mid_rst_nzp", 64'(nzp), 64'(3'b010));
    drive(1'b1, 3'd6, 16'h0001, 3'd6, 3'd3, 1'b1, 3'd3, 1'b0);
    #1 chk("rst_bypass", 64'(sr1_out), 64'(16'h0001));
    @(posedge Clk); #1;
    chk("rst_edge_pend", 64'(pend), 64'(0));
    chk("rst_edge_nzp", 64'(nzp), 64'(3'b010));
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 3'd6, 3'd3, 1'b0, 3'd0, 1'b0);
    Reset = 1'b1;
    #1 chk("rst_edge_reg6", 64'(sr1_out), 64'(0));
    chk("rst_edge_b3", 64'(sr2_busy), 64'(0));

    // Randomized run against the model, starting from the reset state
    for (int i = 0; i < 8; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    m_nzp = 3'b010;
    for (int n = 0; n < 400; n++) begin
      @(negedge Clk);
      drive(($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0));
      if (n % 7 == 0) din = 16'h0000;
      e1  = (ld && dr == sr1) ? din : m_regs[sr1];
      e2  = (ld && dr == sr2) ? din : m_regs[sr2];
      eb1 = m_busy[sr1] && !(ld && dr == sr1);
      eb2 = m_busy[sr2] && !(ld && dr == sr2);
      est = iss && m_busy[idr] && !(ld && dr == idr) && !fl;
      #1;
      chk($sformatf("rnd%0d_sr1", n), 64'(sr1_out), 64'(e1));
      chk($sformatf("rnd%0d_sr2", n), 64'(sr2_out), 64'(e2));
      chk($sformatf("rnd%0d_b1", n), 64'(sr1_busy), 64'(eb1));
      chk($sformatf("rnd%0d_b2", n), 64'(sr2_busy), 64'(eb2));
      chk($sformatf("rnd%0d_stall", n), 64'(stall), 64'(est));
      @(posedge Clk);
      if (ld) begin
        m_regs[dr] = din;
        m_nzp = din[15] ? 3'b100 : (din == 16'h0) ? 3'b010 : 3'b001;
      end
      if (fl) begin
        for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;
      end else begin
        if (ld) m_busy[dr] = 1'b0;
        if (iss && !est) m_busy[idr] = 1'b1;
      end
      #1;
      chk($sformatf("rnd%0d_pend", n), 64'(pend), 64'(m_count()));
      chk($sformatf("rnd%0d_nzp", n), 64'(nzp), 64'(m_nzp));
    end

    // Wide instance: positive small value on the top register
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    w_ld = 1'b1; w_dr = 4'd15; w_din = 32'h0000_0007; w_sr2 = 4'd15; w_sr1 = 4'd0;
    #1 chk("wide_bypass", 64'(w_sr2_out), 64'(32'h7));
    chk("wide_sr1_pre", 64'(w_sr1_out), 64'(0));
    @(posedge Clk); #1 chk("wide_nzp", 64'(w_nzp), 64'(3'b001));
    @(negedge Clk);
    w_ld = 1'b0; w_sr1 = 4'd15;
    #1 chk("wide_read", 64'(w_sr1_out), 64'(32'h7));
    chk("wide_pend", 64'(w_pend), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
